// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel LED PWM dimmer.
package pwm_pkg;

  typedef enum logic {
    BR_RISE = 1'b0,
    BR_FALL = 1'b1
  } breathe_state_t;

  // Phase offset for channel ch: ch * floor((2^res - 1) / num_ch)
  function automatic int unsigned stagger_offset(input int unsigned ch,
                                                 input int unsigned num_ch,
                                                 input int unsigned res);
    return ch * (((32'd1 << res) - 32'd1) / num_ch);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed duty (pending/active), breathe FSM, offset compare
// and registered output. OFFSET is 0 unless the top enables phase staggering.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned RES    = 8,
  parameter int unsigned OFFSET = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_boundary,
  input  logic           i_we,
  input  logic [RES-1:0] i_val,
  input  logic           i_mode,
  input  logic [RES-1:0] i_cnt,
  output logic           o_out
);

  localparam int unsigned    PERIOD = (1 << RES) - 1;
  localparam int unsigned    SUM_W  = RES + 1;
  localparam logic [RES:0]   OFF_W  = SUM_W'(OFFSET);
  localparam logic [RES:0]   PER_W  = SUM_W'(PERIOD);

  logic [RES-1:0] r_pending;
  logic [RES-1:0] r_active;
  logic [RES-1:0] w_active_nxt;
  logic [RES-1:0] w_cmp;
  logic [RES:0]   w_sum;
  logic [RES:0]   w_wrap;
  logic           r_out;

  breathe_state_t r_state;
  breathe_state_t w_state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else if (i_we) begin
      r_pending <= i_val;
    end
  end

  // Breathe FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BR_RISE;
    end else if (i_boundary) begin
      r_state <= w_state_nxt;
    end
  end

  // Breathe FSM: next state; static mode parks the FSM in RISE
  always_comb begin
    w_state_nxt = r_state;
    if (!i_mode) begin
      w_state_nxt = BR_RISE;
    end else begin
      case (r_state)
        BR_RISE: if (!(r_active < r_pending)) w_state_nxt = BR_FALL;
        BR_FALL: if (r_active == '0)          w_state_nxt = BR_RISE;
        default: w_state_nxt = BR_RISE;
      endcase
    end
  end

  // Breathe FSM: output (next active duty); the turn-around period holds active
  always_comb begin
    w_active_nxt = r_active;
    if (!i_mode) begin
      w_active_nxt = r_pending;
    end else begin
      case (r_state)
        BR_RISE: if (r_active < r_pending) w_active_nxt = r_active + RES'(1);
        BR_FALL: if (r_active != '0)       w_active_nxt = r_active - RES'(1);
        default: w_active_nxt = r_active;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
    end else if (i_boundary) begin
      r_active <= w_active_nxt;
    end
  end

  // (cnt + OFFSET) mod PERIOD with a single conditional subtract
  always_comb begin
    w_sum  = {1'b0, i_cnt} + OFF_W;
    w_wrap = w_sum - PER_W;
    w_cmp  = (w_sum >= PER_W) ? w_wrap[RES-1:0] : w_sum[RES-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 1'b0;
    end else begin
      r_out <= (w_cmp < r_active);
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/pwm_multi_dimmer.sv
// Multi-channel LED PWM dimmer: shared prescaler/period counter, per-channel
// shadowed duty and breathe mode. Define PWM_PHASE_STAGGER_EN to stagger channel phases.
module pwm_multi_dimmer
  import pwm_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned RES      = 8,
  parameter  int unsigned PRESCALE = 16,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              duty_we,
  input  logic [CH_W-1:0]   duty_ch,
  input  logic [RES-1:0]    duty_val,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam int unsigned    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam int unsigned    PERIOD   = (1 << RES) - 1;
  localparam logic [RES-1:0] CNT_LAST = RES'(PERIOD - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [RES-1:0]    r_cnt;
  logic              r_period_start;
  logic              w_tick;
  logic              w_boundary;
  logic [NUM_CH-1:0] w_we;
  logic [NUM_CH-1:0] w_out;

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_boundary = w_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_boundary) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + RES'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
    localparam int unsigned OFF = stagger_offset(i, NUM_CH, RES);
`else
    localparam int unsigned OFF = 0;
`endif
    // Out-of-range channel numbers match no channel
    assign w_we[i] = duty_we && (duty_ch == CH_W'(i));

    pwm_channel #(
      .RES    (RES),
      .OFFSET (OFF)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_boundary (w_boundary),
      .i_we       (w_we[i]),
      .i_val      (duty_val),
      .i_mode     (mode[i]),
      .i_cnt      (r_cnt),
      .o_out      (w_out[i])
    );
  end

  assign out          = w_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multi_dimmer.sv
// Self-checking bench for pwm_multi_dimmer (3 channels, RES=4, PRESCALE=1, default build).
module tb_pwm_multi_dimmer;

  localparam int NCH = 3;
  localparam int PER = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       duty_we = 1'b0;
  logic [1:0] duty_ch = '0;
  logic [3:0] duty_val = '0;
  logic [2:0] mode = '0;
  logic [2:0] out;
  logic       period_start;

  always #5 clk = ~clk;

  pwm_multi_dimmer #(
    .NUM_CH   (NCH),
    .RES      (4),
    .PRESCALE (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .duty_we      (duty_we),
    .duty_ch      (duty_ch),
    .duty_val     (duty_val),
    .mode         (mode),
    .out          (out),
    .period_start (period_start)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position within period, pending/active duty, breathe direction
  int m_cnt;
  int m_pend[NCH];
  int m_act[NCH];
  bit m_fall[NCH];
  int rec_act[NCH];
  int acc[NCH];
  int last_cnt[NCH];
  bit full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [2:0] nxt_out;
    logic       bnd;
    nxt_out = '0;
    bnd     = 1'b0;
    if (rst) begin
      m_cnt = 0;
      full  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_pend[i] = 0; m_act[i] = 0; m_fall[i] = 0; acc[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) nxt_out[i] = (m_cnt < m_act[i]);
      bnd = (m_cnt == PER - 1);
      if (bnd) begin
        for (int i = 0; i < NCH; i++) begin
          if (!mode[i]) begin
            m_act[i] = m_pend[i]; m_fall[i] = 0;
          end else if (!m_fall[i]) begin
            if (m_act[i] < m_pend[i]) m_act[i]++; else m_fall[i] = 1;
          end else begin
            if (m_act[i] > 0) m_act[i]--; else m_fall[i] = 0;
          end
        end
      end
      if (duty_we && int'(duty_ch) < NCH) m_pend[duty_ch] = int'(duty_val);
      m_cnt = bnd ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out", 32'(out), 32'(nxt_out));
    chk("period_start", 32'(period_start), 32'(bnd));
    for (int i = 0; i < NCH; i++) acc[i] += int'(out[i]);
    if (period_start) begin
      for (int i = 0; i < NCH; i++) begin
        if (full) chk("period_high_count", acc[i], rec_act[i]);
        last_cnt[i] = acc[i];
        acc[i]      = 0;
        rec_act[i]  = m_act[i];
      end
      full = 1;
    end
  endtask

  task automatic wr(input int ch, input int val);
    duty_we  = 1'b1;
    duty_ch  = 2'(ch);
    duty_val = 4'(val);
    step();
    duty_we  = 1'b0;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 40);
    chk("period_start_seen", 32'(period_start), 32'd1);
  endtask

  task automatic go_cnt(input int c);
    for (int k = 0; k < 20 && m_cnt != c; k++) step();
  endtask

  int n;
  int breathe_exp[9] = '{1, 2, 3, 3, 2, 1, 0, 0, 1};

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_period_start", 32'(period_start), 32'd0);
    rst = 1'b0;

    // Static duties
    wr(0, 5);
    wr(1, 15);
    wait_ps(n);
    wait_ps(n);
    wait_ps(n);
    chk("ps_spacing", n, PER);
    chk("static_ch0_5", last_cnt[0], 5);
    chk("static_ch1_full", last_cnt[1], 15);
    chk("static_ch2_zero", last_cnt[2], 0);

    // Zero duty and out-of-range channel
    wr(0, 0);
    repeat (4) wait_ps(n);
    chk("zero_duty", last_cnt[0], 0);
    wr(3, 7);
    repeat (3) wait_ps(n);
    chk("oor_ch0", last_cnt[0], 0);
    chk("oor_ch1", last_cnt[1], 15);
    chk("oor_ch2", last_cnt[2], 0);

    // Mid-period write keeps the current period
    wr(0, 3);
    wait_ps(n);
    wait_ps(n);
    go_cnt(5);
    wr(0, 9);
    wait_ps(n);
    chk("midwrite_current", last_cnt[0], 3);
    wait_ps(n);
    chk("midwrite_next", last_cnt[0], 9);

    // Write in the boundary cycle lands one period later
    go_cnt(PER - 1);
    wr(0, 12);
    wait_ps(n);
    chk("bndwrite_old", last_cnt[0], 9);
    wait_ps(n);
    chk("bndwrite_new", last_cnt[0], 12);

    // Breathe from active 0 up to peak 3 and back
    wr(0, 0);
    wait_ps(n);
    mode[0] = 1'b1;
    wr(0, 3);
    wait_ps(n);
    for (int k = 0; k < 9; k++) begin
      wait_ps(n);
      chk("breathe_count", last_cnt[0], breathe_exp[k]);
    end
    mode[0] = 1'b0;

    // Reset mid-period while ch1 is high
    go_cnt(6);
    rst = 1'b1;
    step();
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_ps", 32'(period_start), 32'd0);
    rst = 1'b0;
    wait_ps(n);
    chk("post_rst_first_ps", n, PER);
    wait_ps(n);
    chk("post_rst_ch1_low", last_cnt[1], 0);

    // Randomized writes and mode changes against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) begin
        duty_we  = 1'b1;
        duty_ch  = 2'($urandom_range(3));
        duty_val = 4'($urandom_range(15));
      end else begin
        duty_we = 1'b0;
      end
      if ($urandom_range(30) == 0) mode = 3'($urandom_range(7));
      step();
    end
    duty_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
